// File: rtl/multicycle_alu_if.sv
// rtl/multicycle_alu_if.sv - issue/result bundle between EX operand muxes and the ALU
interface multicycle_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, op, a, b,
    input  result, zero, busy, done, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output result, zero, busy, done, div_by_zero
  );
endinterface

// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - EX-stage ALU with single-cycle ops and iterative MOD/SQRT
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  multicycle_alu_if.slave bus
);
  localparam int H  = WIDTH / 2;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_MUL   = 4'b0011;
  localparam logic [3:0] OP_MOD   = 4'b0100;
  localparam logic [3:0] OP_SQRT  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SHIFT = 4'b1111;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_SQRT} state_t;

  state_t state, state_nxt;

  // opa is the dividend/radicand shifted out MSB-first; opb holds the divisor
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] drem;
  logic [H+1:0]     srem;
  logic [H-1:0]     root;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             done_q;
  logic             dbz_q;

  logic             launch;
  logic             last;
  logic [WIDTH-1:0] single_res;
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_nxt;
  logic [H+3:0]     sq_sh;
  logic [H+3:0]     sq_trial;
  logic             sq_ge;
  logic [H+1:0]     sq_rem_nxt;
  logic [H-1:0]     sq_root_nxt;

  assign launch = (state == S_IDLE) && bus.start;
  assign last   = (cnt == CW'(1));

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // next-state: iterative ops leave IDLE, return on their final step
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.op == OP_MOD && bus.b != '0) state_nxt = S_DIV;
          else if (bus.op == OP_SQRT)          state_nxt = S_SQRT;
        end
      end
      S_DIV:   if (last) state_nxt = S_IDLE;
      S_SQRT:  if (last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // outputs: busy follows the state, the rest come straight from registers
  always_comb begin
    bus.busy        = (state != S_IDLE);
    bus.result      = result_q;
    bus.zero        = zero_q;
    bus.done        = done_q;
    bus.div_by_zero = dbz_q;
  end

  // single-cycle datapath; MOD/SQRT/undefined fall to zero here
  always_comb begin
    single_res = '0;
    case (bus.op)
      OP_AND:   single_res = bus.a & bus.b;
      OP_OR:    single_res = bus.a | bus.b;
      OP_ADD:   single_res = bus.a + bus.b;
      OP_SUB:   single_res = bus.a - bus.b;
      OP_MUL:   single_res = bus.a * bus.b;
      OP_SLT:   single_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SHIFT: single_res = bus.a << bus.b[4:0];
      default:  single_res = '0;
    endcase
  end

  // one restoring-division step and one square-root digit step
  always_comb begin
    div_sh      = {drem, opa[WIDTH-1]};
    div_ge      = (div_sh >= {1'b0, opb});
    div_rem_nxt = div_ge ? WIDTH'(div_sh - {1'b0, opb}) : div_sh[WIDTH-1:0];
    sq_sh       = {srem, opa[WIDTH-1:WIDTH-2]};
    sq_trial    = {2'b00, root, 2'b01};
    sq_ge       = (sq_sh >= sq_trial);
    sq_rem_nxt  = sq_ge ? (H+2)'(sq_sh - sq_trial) : sq_sh[H+1:0];
    sq_root_nxt = {root[H-2:0], sq_ge};
  end

  // datapath registers: launch, iterate, and publish result/flags on completion
  always_ff @(posedge clk) begin
    if (rst) begin
      opa      <= '0;
      opb      <= '0;
      drem     <= '0;
      srem     <= '0;
      root     <= '0;
      cnt      <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (launch) begin
            if (bus.op == OP_MOD) begin
              if (bus.b == '0) begin
                result_q <= bus.a;
                zero_q   <= (bus.a == '0);
                dbz_q    <= 1'b1;
                done_q   <= 1'b1;
              end else begin
                opa  <= bus.a;
                opb  <= bus.b;
                drem <= '0;
                cnt  <= CW'(WIDTH);
              end
            end else if (bus.op == OP_SQRT) begin
              opa  <= bus.a;
              root <= '0;
              srem <= '0;
              cnt  <= CW'(H);
            end else begin
              result_q <= single_res;
              zero_q   <= (single_res == '0);
              dbz_q    <= 1'b0;
              done_q   <= 1'b1;
            end
          end
        end
        S_DIV: begin
          opa  <= opa << 1;
          drem <= div_rem_nxt;
          cnt  <= cnt - CW'(1);
          if (last) begin
            result_q <= div_rem_nxt;
            zero_q   <= (div_rem_nxt == '0);
            dbz_q    <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        S_SQRT: begin
          opa  <= opa << 2;
          srem <= sq_rem_nxt;
          root <= sq_root_nxt;
          cnt  <= cnt - CW'(1);
          if (last) begin
            result_q <= {{(WIDTH-H){1'b0}}, sq_root_nxt};
            zero_q   <= (sq_root_nxt == '0);
            dbz_q    <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_alu.sv
// tb/tb_multicycle_alu.sv - directed self-checking bench for multicycle_alu
module tb_multicycle_alu;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cyc;
  int   pulses;

  multicycle_alu_if #(.WIDTH(32)) bus ();

  multicycle_alu #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // drive one start at a negedge; returns #1 after the accepting edge
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // count edges until done, bounded; also count done pulses seen
  task automatic wait_done(output int cycles, output int npulse);
    cycles = 0;
    npulse = 0;
    while (bus.done !== 1'b1 && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
      if (bus.done === 1'b1 && bus.busy === 1'b1) check("done_with_busy", 32'd1, 32'd0);
    end
    if (bus.done === 1'b1) npulse = 1;
    @(posedge clk);
    #1;
    if (bus.done === 1'b1) npulse++;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.start = 1'b0;
    bus.op    = 4'b0000;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", bus.result, 32'h0);
    check("rst_zero", {31'b0, bus.zero}, 32'd1);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_dbz", {31'b0, bus.div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(4'b0000, 32'h0000F0F0, 32'h00000FF0);
    check("and_done", {31'b0, bus.done}, 32'd1);
    check("and_result", bus.result, 32'h000000F0);
    check("and_zero", {31'b0, bus.zero}, 32'd0);
    @(posedge clk);
    #1;
    check("and_done_drop", {31'b0, bus.done}, 32'd0);

    issue(4'b0001, 32'h000000F0, 32'h0000000F);
    check("or_result", bus.result, 32'h000000FF);
    issue(4'b0110, 32'd5, 32'd5);
    check("sub_result", bus.result, 32'h0);
    check("sub_zero", {31'b0, bus.zero}, 32'd1);
    issue(4'b0111, 32'hFFFFFFFF, 32'd1);
    check("slt_result", bus.result, 32'd1);
    issue(4'b1111, 32'd1, 32'd31);
    check("shift_result", bus.result, 32'h80000000);
    issue(4'b0011, 32'h00012345, 32'h00000100);
    check("mul_result", bus.result, 32'h01234500);
    issue(4'b1000, 32'd7, 32'd9);
    check("undef_result", bus.result, 32'h0);
    check("undef_zero", {31'b0, bus.zero}, 32'd1);
    check("undef_done", {31'b0, bus.done}, 32'd1);

    issue(4'b0100, 32'd100, 32'd7);
    check("mod_busy", {31'b0, bus.busy}, 32'd1);
    check("mod_no_done", {31'b0, bus.done}, 32'd0);
    wait_done(cyc, pulses);
    check("mod_cycles", cyc, 32'd32);
    check("mod_result", bus.result, 32'd2);
    check("mod_pulses", pulses, 32'd1);
    check("mod_busy_end", {31'b0, bus.busy}, 32'd0);

    issue(4'b0100, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    issue(4'b0010, 32'd1, 32'd1);
    wait_done(cyc, pulses);
    check("mod_restart_cycles", cyc, 32'd27);
    check("mod_restart_result", bus.result, 32'd2);
    check("mod_restart_pulses", pulses, 32'd1);

    issue(4'b0100, 32'h1234, 32'd0);
    check("dbz_done", {31'b0, bus.done}, 32'd1);
    check("dbz_busy", {31'b0, bus.busy}, 32'd0);
    check("dbz_result", bus.result, 32'h1234);
    check("dbz_flag", {31'b0, bus.div_by_zero}, 32'd1);
    issue(4'b0010, 32'd10, 32'd20);
    check("add_result", bus.result, 32'd30);
    check("add_dbz_clear", {31'b0, bus.div_by_zero}, 32'd0);
    issue(4'b0110, 32'd10, 32'd4);
    check("b2b_sub_result", bus.result, 32'd6);
    check("b2b_sub_done", {31'b0, bus.done}, 32'd1);

    issue(4'b0101, 32'd1000000, 32'd0);
    wait_done(cyc, pulses);
    check("sqrt_cycles", cyc, 32'd16);
    check("sqrt_result", bus.result, 32'd1000);
    issue(4'b0101, 32'hFFFFFFFF, 32'd0);
    wait_done(cyc, pulses);
    check("sqrt_max", bus.result, 32'h0000FFFF);
    issue(4'b0101, 32'd0, 32'd0);
    wait_done(cyc, pulses);
    check("sqrt_zero_result", bus.result, 32'h0);
    check("sqrt_zero_flag", {31'b0, bus.zero}, 32'd1);
    issue(4'b0101, 32'd99, 32'd0);
    wait_done(cyc, pulses);
    check("sqrt_99", bus.result, 32'd9);

    issue(4'b0100, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", {31'b0, bus.busy}, 32'd0);
    check("abort_result", bus.result, 32'h0);
    check("abort_zero", {31'b0, bus.zero}, 32'd1);
    check("abort_done", {31'b0, bus.done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) pulses++;
    end
    check("abort_no_pulse", pulses, 32'd0);
    issue(4'b0010, 32'd2, 32'd3);
    check("post_abort_add", bus.result, 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
